// File: rtl/bt_recursion_sched.sv
// Backtracking search sequencer for the ex stage.
// Keeps the current frame plus a call stack and steps fetch/exec/update.
//
// Ports:
//   clk, rst_n (sync, active-low)
//   start, i0/z0/k0/l0      : launch with root frame
//   busy, done, err_ovf     : search status
//   en_ex, pos_out, *_out   : phase and current frame to ex
//   mem_req / mem_ack       : occurrence-data fetch handshake
//   over_1, over_2, new_call, finish, en_new_position,
//   new_position, *_new     : ex results, sampled in EXEC
//   hit_valid, hit_k/l, hit_cnt : match reporting
module bt_recursion_sched #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int PW    = 5,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  i0,
  input  logic [W-1:0]  z0,
  input  logic [W-1:0]  k0,
  input  logic [W-1:0]  l0,
  output logic          busy,
  output logic          done,
  output logic          err_ovf,
  output logic [2:0]    en_ex,
  output logic [PW-1:0] pos_out,
  output logic [W-1:0]  i_out,
  output logic [W-1:0]  z_out,
  output logic [W-1:0]  k_out,
  output logic [W-1:0]  l_out,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic          over_1,
  input  logic          over_2,
  input  logic          en_new_position,
  input  logic          new_call,
  input  logic          finish,
  input  logic [PW-1:0] new_position,
  input  logic [W-1:0]  i_new,
  input  logic [W-1:0]  z_new,
  input  logic [W-1:0]  k_new,
  input  logic [W-1:0]  l_new,
  output logic          hit_valid,
  output logic [W-1:0]  hit_k,
  output logic [W-1:0]  hit_l,
  output logic [15:0]   hit_cnt
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] POS_NONE = '0;
  localparam logic [31:0]   AW_L = AW;

  typedef struct packed {
    logic [PW-1:0] pos;
    logic [W-1:0]  i;
    logic [W-1:0]  z;
    logic [W-1:0]  k;
    logic [W-1:0]  l;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_UPD,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  frame_t cur;
  frame_t stack [DEPTH];
  logic [SW-1:0] sp, sp_m1;
  logic [IW-1:0] wr_idx, rd_idx;
  logic sp_full, sp_empty;

  logic r_o1, r_o2, r_nc, r_fin, r_enp;
  logic [PW-1:0] r_npos;
  frame_t r_child;

  logic do_push, do_pop, do_hit, do_ovf, do_pos, ret;
  logic unused_aw;

  assign unused_aw = AW_L[0];

  assign sp_m1    = sp - SW'(1);
  assign wr_idx   = sp[IW-1:0];
  assign rd_idx   = sp_m1[IW-1:0];
  assign sp_full  = (sp == SW'(DEPTH));
  assign sp_empty = (sp == '0);

  assign pos_out = cur.pos;
  assign i_out   = cur.i;
  assign z_out   = cur.z;
  assign k_out   = cur.k;
  assign l_out   = cur.l;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_ex     = 3'b000;
    mem_req   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_hit    = 1'b0;
    do_ovf    = 1'b0;
    do_pos    = 1'b0;
    ret       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        en_ex   = 3'b001;
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        en_ex     = 3'b011;
        busy      = 1'b1;
        state_nxt = S_UPD;
      end
      S_UPD: begin
        busy      = 1'b1;
        state_nxt = S_FETCH;
        // One action per update, highest priority first.
        if (r_o2) begin
          do_hit = 1'b1;
          ret    = 1'b1;
        end else if (r_o1) begin
          ret = 1'b1;
        end else if (r_nc) begin
          if (sp_full) begin
            do_ovf    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            do_push = 1'b1;
          end
        end else if (r_fin) begin
          ret = 1'b1;
        end else if (r_enp) begin
          do_pos = 1'b1;
        end
        if (ret) begin
          if (sp_empty) state_nxt = S_DONE;
          else          do_pop    = 1'b1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= '0;
      sp        <= '0;
      err_ovf   <= 1'b0;
      hit_valid <= 1'b0;
      hit_k     <= '0;
      hit_l     <= '0;
      hit_cnt   <= '0;
      r_o1      <= 1'b0;
      r_o2      <= 1'b0;
      r_nc      <= 1'b0;
      r_fin     <= 1'b0;
      r_enp     <= 1'b0;
      r_npos    <= '0;
      r_child   <= '0;
    end else begin
      hit_valid <= 1'b0;
      if (state == S_IDLE && start) begin
        cur     <= '{pos: POS_NONE, i: i0, z: z0, k: k0, l: l0};
        sp      <= '0;
        hit_cnt <= '0;
        err_ovf <= 1'b0;
      end
      if (state == S_EXEC) begin
        r_o1    <= over_1;
        r_o2    <= over_2;
        r_nc    <= new_call;
        r_fin   <= finish;
        r_enp   <= en_new_position;
        r_npos  <= new_position;
        r_child <= '{pos: POS_NONE, i: i_new, z: z_new,
                     k: k_new, l: l_new};
      end
      if (do_hit) begin
        hit_valid <= 1'b1;
        hit_k     <= cur.k;
        hit_l     <= cur.l;
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end
      if (do_ovf) err_ovf <= 1'b1;
      if (do_push) begin
        sp  <= sp + SW'(1);
        cur <= r_child;
      end
      if (do_pop) begin
        sp  <= sp_m1;
        cur <= stack[rd_idx];
      end
      if (do_pos) cur.pos <= r_npos;
    end
  end

  // Suspended frame resumes at the position ex handed back with the call.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      stack[wr_idx] <= '{pos: r_npos, i: cur.i, z: cur.z,
                         k: cur.k, l: cur.l};
    end
  end

endmodule

// File: tb/tb_bt_recursion_sched.sv
// Bench for bt_recursion_sched: queue-based search model,
// directed scenarios, then randomized ex/fetch behaviour.
module tb_bt_recursion_sched;

  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int PW    = 5;
  localparam int AW    = 12;
  localparam int A_INS = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;
  localparam int PH_UPD   = 3;
  localparam int PH_DONE  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] i0, z0, k0, l0;
  logic busy, done, err_ovf, mem_req, mem_ack;
  logic [2:0] en_ex;
  logic [PW-1:0] pos_out, new_position;
  logic [W-1:0] i_out, z_out, k_out, l_out;
  logic over_1, over_2, en_new_position, new_call, finish;
  logic [W-1:0] i_new, z_new, k_new, l_new;
  logic hit_valid;
  logic [W-1:0] hit_k, hit_l;
  logic [15:0] hit_cnt;

  always #5 clk = ~clk;

  bt_recursion_sched #(
    .DEPTH(DEPTH), .W(W), .PW(PW), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .i0(i0), .z0(z0), .k0(k0), .l0(l0),
    .busy(busy), .done(done), .err_ovf(err_ovf),
    .en_ex(en_ex), .pos_out(pos_out),
    .i_out(i_out), .z_out(z_out), .k_out(k_out), .l_out(l_out),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .over_1(over_1), .over_2(over_2),
    .en_new_position(en_new_position),
    .new_call(new_call), .finish(finish),
    .new_position(new_position),
    .i_new(i_new), .z_new(z_new), .k_new(k_new), .l_new(l_new),
    .hit_valid(hit_valid), .hit_k(hit_k), .hit_l(hit_l),
    .hit_cnt(hit_cnt)
  );

  typedef struct {
    int pos;
    int i;
    int z;
    int k;
    int l;
  } mframe_t;

  int checks = 0;
  int errors = 0;

  int m_ph;
  mframe_t m_cur;
  mframe_t stk [$];
  int m_hv, m_hk, m_hl, m_cnt, m_err;
  int s_o1, s_o2, s_nc, s_fin, s_enp, s_npos;
  mframe_t s_child;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph  = PH_IDLE;
    m_cur = '{0, 0, 0, 0, 0};
    stk.delete();
    m_hv  = 0;
    m_hk  = 0;
    m_hl  = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // Applies the inputs of the current cycle to the search model.
  task automatic model_step();
    bit r;
    m_hv = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_ph)
      PH_IDLE: begin
        if (start) begin
          m_cur = '{0, int'(i0), int'(z0), int'(k0), int'(l0)};
          stk.delete();
          m_cnt = 0;
          m_err = 0;
          m_ph  = PH_FETCH;
        end
      end
      PH_FETCH: if (mem_ack) m_ph = PH_EXEC;
      PH_EXEC: begin
        s_o1    = int'(over_1);
        s_o2    = int'(over_2);
        s_nc    = int'(new_call);
        s_fin   = int'(finish);
        s_enp   = int'(en_new_position);
        s_npos  = int'(new_position);
        s_child = '{0, int'(i_new), int'(z_new), int'(k_new),
                    int'(l_new)};
        m_ph    = PH_UPD;
      end
      PH_UPD: begin
        r = 0;
        m_ph = PH_FETCH;
        if (s_o2 != 0) begin
          m_hv = 1;
          m_hk = m_cur.k;
          m_hl = m_cur.l;
          if (m_cnt < 65535) m_cnt++;
          r = 1;
        end else if (s_o1 != 0) begin
          r = 1;
        end else if (s_nc != 0) begin
          if (stk.size() == DEPTH) begin
            m_err = 1;
            m_ph  = PH_DONE;
          end else begin
            stk.push_back('{s_npos, m_cur.i, m_cur.z, m_cur.k,
                            m_cur.l});
            m_cur = s_child;
          end
        end else if (s_fin != 0) begin
          r = 1;
        end else if (s_enp != 0) begin
          m_cur.pos = s_npos;
        end
        if (r) begin
          if (stk.size() == 0) m_ph = PH_DONE;
          else m_cur = stk.pop_back();
        end
      end
      PH_DONE: m_ph = PH_IDLE;
      default: m_ph = PH_IDLE;
    endcase
  endtask

  task automatic compare();
    int ee;
    ee = (m_ph == PH_FETCH) ? 1 : (m_ph == PH_EXEC) ? 3 : 0;
    chk("busy", busy, 32'(m_ph inside {PH_FETCH, PH_EXEC, PH_UPD}));
    chk("done", done, 32'(m_ph == PH_DONE));
    chk("en_ex", en_ex, ee);
    chk("mem_req", mem_req, 32'(m_ph == PH_FETCH));
    chk("err_ovf", err_ovf, m_err);
    chk("pos_out", pos_out, m_cur.pos);
    chk("i_out", i_out, m_cur.i);
    chk("z_out", z_out, m_cur.z);
    chk("k_out", k_out, m_cur.k);
    chk("l_out", l_out, m_cur.l);
    chk("hit_valid", hit_valid, m_hv);
    chk("hit_k", hit_k, m_hk);
    chk("hit_l", hit_l, m_hl);
    chk("hit_cnt", hit_cnt, m_cnt);
  endtask

  task automatic tick();
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 0;
    i0 = 0; z0 = 0; k0 = 0; l0 = 0;
    mem_ack = 0;
    over_1 = 0; over_2 = 0; new_call = 0;
    finish = 0; en_new_position = 0;
    new_position = 0;
    i_new = 0; z_new = 0; k_new = 0; l_new = 0;
  endtask

  task automatic launch(input int a, input int b, input int c,
                        input int d);
    start = 1;
    i0 = W'(a); z0 = W'(b); k0 = W'(c); l0 = W'(d);
    tick();
    start = 0;
  endtask

  // Walks one frame: fetch (acked), exec with given results, update.
  task automatic run_frame(input bit o2, input bit o1, input bit nc,
                           input bit fin, input bit enp,
                           input int np = 0, input int ci = 0,
                           input int cz = 0, input int ck = 0,
                           input int cl = 0);
    int n;
    n = 0;
    mem_ack = 1;
    while (m_ph != PH_EXEC && n < 20) begin
      tick();
      n++;
    end
    if (m_ph != PH_EXEC) chk("exec_timeout", 32'(m_ph), PH_EXEC);
    over_2 = o2; over_1 = o1; new_call = nc;
    finish = fin; en_new_position = enp;
    new_position = PW'(np);
    i_new = W'(ci); z_new = W'(cz); k_new = W'(ck); l_new = W'(cl);
    tick();
    over_2 = 0; over_1 = 0; new_call = 0;
    finish = 0; en_new_position = 0;
    tick();
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    @(posedge clk);
    #1;
    model_reset();
    tick();
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_en", en_ex, 0);
    chk("lit_rst_cnt", hit_cnt, 0);
    rst_n = 1;
    tick();

    // immediate stop
    launch(1, 8'hFF, 2, 3);
    run_frame(0, 1, 0, 0, 0);
    chk("lit_stop_done", done, 1);
    chk("lit_stop_cnt", hit_cnt, 0);
    chk("lit_stop_ovf", err_ovf, 0);
    tick();
    chk("lit_stop_idle", busy, 0);

    // single hit in a child frame, then parent resumes
    launch(3, 1, 2, 4);
    run_frame(0, 0, 1, 0, 0, A_INS, 8'hFF, 0, 5, 9);
    chk("lit_child_i", i_out, 8'hFF);
    chk("lit_child_pos", pos_out, 0);
    run_frame(1, 0, 0, 0, 0);
    chk("lit_hit_v", hit_valid, 1);
    chk("lit_hit_k", hit_k, 5);
    chk("lit_hit_l", hit_l, 9);
    chk("lit_hit_cnt", hit_cnt, 1);
    chk("lit_pop_pos", pos_out, A_INS);
    chk("lit_pop_i", i_out, 3);
    run_frame(0, 1, 0, 0, 0);
    chk("lit_hit_done", done, 1);
    chk("lit_hit_hold", hit_k, 5);
    tick();

    // overflow: DEPTH calls fill the stack, the next one overflows
    launch(1, 1, 1, 1);
    for (int n = 0; n < DEPTH; n++) run_frame(0, 0, 1, 0, 0, 2, n + 10);
    chk("lit_full_busy", busy, 1);
    run_frame(0, 0, 1, 0, 0, 2, 99);
    chk("lit_ovf", err_ovf, 1);
    chk("lit_ovf_done", done, 1);
    tick();
    chk("lit_ovf_nofetch", en_ex, 0);
    chk("lit_ovf_sticky", err_ovf, 1);
    tick();

    // over_2 beats new_call: pop instead of push
    launch(4, 0, 0, 0);
    run_frame(0, 0, 1, 0, 0, 6, 7, 0, 1, 2);
    run_frame(1, 0, 1, 0, 0, 9, 8);
    chk("lit_pri_hv", hit_valid, 1);
    chk("lit_pri_cnt", hit_cnt, 1);
    chk("lit_pri_pos", pos_out, 6);
    chk("lit_pri_i", i_out, 4);
    run_frame(0, 1, 0, 0, 0);
    chk("lit_pri_done", done, 1);
    tick();

    // fetch stall
    mem_ack = 0;
    launch(5, 0, 0, 0);
    for (int n = 0; n < 7; n++) begin
      chk("lit_stall_en", en_ex, 3'b001);
      chk("lit_stall_req", mem_req, 1);
      tick();
    end
    mem_ack = 1;
    tick();
    chk("lit_stall_exec", en_ex, 3'b011);
    chk("lit_stall_noreq", mem_req, 0);
    mem_ack = 0;
    over_1 = 1;
    tick();
    over_1 = 0;
    chk("lit_stall_upd", en_ex, 0);
    tick();
    chk("lit_stall_done", done, 1);
    tick();

    // reset mid-fetch with three suspended frames
    launch(1, 2, 3, 4);
    for (int n = 0; n < 3; n++) run_frame(0, 0, 1, 0, 0, 1, 7, 7, 7, 7);
    mem_ack = 0;
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("lit_mrst_busy", busy, 0);
    chk("lit_mrst_en", en_ex, 0);
    chk("lit_mrst_i", i_out, 0);
    chk("lit_mrst_req", mem_req, 0);
    chk("lit_mrst_done", done, 0);
    tick();
    chk("lit_mrst_nodone", done, 0);
    launch(2, 0, 0, 0);
    chk("lit_mrst_i0", i_out, 2);
    run_frame(0, 1, 0, 0, 0);
    chk("lit_mrst_fin", done, 1);
    tick();

    // randomized ex and memory behaviour
    for (int n = 0; n < 6000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      start = ($urandom_range(0, 3) == 0);
      i0 = W'($urandom); z0 = W'($urandom);
      k0 = W'($urandom); l0 = W'($urandom);
      mem_ack = ($urandom_range(0, 2) != 0);
      over_2 = ($urandom_range(0, 99) < 12);
      over_1 = ($urandom_range(0, 99) < 15);
      new_call = ($urandom_range(0, 99) < 40);
      finish = ($urandom_range(0, 99) < 10);
      en_new_position = ($urandom_range(0, 99) < 30);
      new_position = PW'($urandom);
      i_new = W'($urandom); z_new = W'($urandom);
      k_new = W'($urandom); l_new = W'($urandom);
      tick();
    end
    compare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
